// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: arbiter state encoding, default sizes and counter width helper
package dmem_arb_pkg;
  typedef enum logic {S_CPU, S_HOST} arb_state_e;
  localparam int AW_DEF = 16;
  localparam int DW_DEF = 32;
  localparam int HOST_MAX_WAIT_DEF = 8;
  localparam int BURST_MAX_DEF = 16;
  function automatic int cnt_w(input int n);
    return n > 2 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port data memory between CPU MEM stage (priority) and a host burst port
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int HOST_MAX_WAIT = HOST_MAX_WAIT_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          c_stall,
  input  logic          h_valid,
  output logic          h_ready,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  input  logic          h_last,
  output logic          h_rvalid,
  output logic [DW-1:0] h_rdata,
  output logic [AW-1:0] m_addr,
  output logic          m_we,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);
  localparam int WW = cnt_w(HOST_MAX_WAIT);
  localparam int BW = cnt_w(BURST_MAX);
  arb_state_e state;
  logic [WW-1:0] wait_cnt;
  logic [BW-1:0] beat_cnt;
  logic c_gnt, h_gnt, starve, burst_end;
  always_comb begin
    c_gnt = state == S_CPU && c_req;
    h_gnt = state == S_HOST ? h_valid : h_valid && !c_req;
    starve = wait_cnt == WW'(HOST_MAX_WAIT - 1);
    burst_end = h_last || beat_cnt == BW'(BURST_MAX - 1);
  end
  assign c_stall = c_req && !c_gnt;
  assign h_ready = h_gnt;
  assign c_rdata = m_rdata;
  assign m_addr  = c_gnt ? c_addr : h_addr;
  assign m_we    = c_gnt ? c_we : h_gnt && h_we;
  assign m_wdata = c_gnt ? c_wdata : h_wdata;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_CPU;
      wait_cnt <= '0;
      beat_cnt <= '0;
      h_rvalid <= 1'b0;
      h_rdata <= '0;
    end else begin
      h_rvalid <= h_gnt && !h_we;
      if (h_gnt && !h_we) h_rdata <= m_rdata;
      if (state == S_CPU) begin
        if (c_req && h_valid) begin
          wait_cnt <= starve ? '0 : wait_cnt + 1'b1;
          if (starve) begin
            state <= S_HOST;
            beat_cnt <= '0;
          end
        end else wait_cnt <= '0;
        if (h_gnt && !h_last && BURST_MAX > 1) begin
          state <= S_HOST;
          beat_cnt <= BW'(1);
        end
      end else if (h_valid && !burst_end) beat_cnt <= beat_cnt + 1'b1;
      else begin
        state <= S_CPU;
        beat_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: random and directed checks of dmem_arbiter against a behavioural model
module tb_dmem_arbiter;
  localparam int HMW = 8;
  localparam int BM = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  logic c_req = 0, c_we = 0, h_valid = 0, h_we = 0, h_last = 0;
  logic [15:0] c_addr = 0, h_addr = 0, m_addr;
  logic [31:0] c_wdata = 0, h_wdata = 0, c_rdata, h_rdata, m_wdata, m_rdata;
  logic c_stall, h_ready, h_rvalid, m_we;
  logic [31:0] mem [256] = '{default: 32'h0};
  logic [31:0] ref_mem [256] = '{default: 32'h0};
  int vectors = 0, errors = 0;
  bit own = 0, rv_exp = 0;
  int waited = 0, beats = 0;
  logic [31:0] rd_exp = 0;
  logic s_h_ready, s_c_stall, s_h_rvalid;
  logic [31:0] s_c_rdata, s_h_rdata;

  dmem_arbiter #(.AW(16), .DW(32), .HOST_MAX_WAIT(HMW), .BURST_MAX(BM)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_rdata(c_rdata), .c_stall(c_stall),
    .h_valid(h_valid), .h_ready(h_ready), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_last(h_last),
    .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (m_we) mem[m_addr[7:0]] <= m_wdata;
  assign m_rdata = mem[m_addr[7:0]];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    own = 0;
    waited = 0;
    beats = 0;
    rv_exp = 0;
  endtask

  task automatic cyc(input bit cr, input bit cw, input logic [15:0] ca, input logic [31:0] cd,
                     input bit hv, input bit hw, input logic [15:0] ha, input logic [31:0] hd, input bit hl);
    bit cg, hg, n_rv, wr;
    logic [7:0] wa;
    logic [31:0] wd, n_rd;
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    h_valid = hv; h_we = hw; h_addr = ha; h_wdata = hd; h_last = hl;
    @(negedge clk);
    cg = !own && cr;
    hg = own ? hv : hv && !cr;
    chk("c_stall", c_stall, cr && !cg);
    chk("h_ready", h_ready, hg);
    chk("m_we", m_we, cg ? cw : hg && hw);
    if (cg || hg) chk("m_addr", m_addr, cg ? ca : ha);
    if ((cg && cw) || (hg && hw)) chk("m_wdata", m_wdata, cg ? cd : hd);
    if (cg && !cw) chk("c_rdata", c_rdata, ref_mem[ca[7:0]]);
    chk("h_rvalid", h_rvalid, rv_exp);
    if (rv_exp) chk("h_rdata", h_rdata, rd_exp);
    s_h_ready = h_ready; s_c_stall = c_stall; s_c_rdata = c_rdata;
    s_h_rvalid = h_rvalid; s_h_rdata = h_rdata;
    wr = (cg && cw) || (hg && hw);
    wa = cg ? ca[7:0] : ha[7:0];
    wd = cg ? cd : hd;
    n_rv = hg && !hw;
    n_rd = ref_mem[ha[7:0]];
    if (!own) begin
      if (cr && hv) begin
        if (waited + 1 >= HMW) begin own = 1; waited = 0; beats = 0; end
        else waited++;
      end else waited = 0;
      if (hg && !hl && BM > 1) begin own = 1; beats = 1; end
    end else if (hv) begin
      beats++;
      if (hl || beats >= BM) begin own = 0; beats = 0; end
    end else begin
      own = 0; beats = 0;
    end
    @(posedge clk);
    #1;
    if (wr) ref_mem[wa] = wd;
    rv_exp = n_rv;
    if (n_rv) rd_exp = n_rd;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int n, beat, run, maxrun;
    c_req = 1; h_valid = 1;
    #3;
    chk("rst_c_stall", c_stall, 0);
    chk("rst_h_ready", h_ready, 0);
    chk("rst_h_rvalid", h_rvalid, 0);
    chk("rst_h_rdata", h_rdata, 0);
    c_req = 0; h_valid = 0;
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
    idle();
    cyc(1, 1, 16'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    chk("cpu_st_stall", s_c_stall, 0);
    cyc(1, 0, 16'h10, 0, 0, 0, 0, 0, 0);
    chk("cpu_ld_stall", s_c_stall, 0);
    chk("cpu_ld_data", s_c_rdata, 32'hDEADBEEF);
    cyc(0, 0, 0, 0, 1, 0, 16'h10, 0, 1);
    chk("host_rd_ready", s_h_ready, 1);
    idle();
    chk("host_rd_rvalid", s_h_rvalid, 1);
    chk("host_rd_data", s_h_rdata, 32'hDEADBEEF);
    idle();
    chk("host_rd_pulse", s_h_rvalid, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 16'h3, 0, 1, 0, 16'h10, 0, 1);
      if (s_h_ready) break;
      n++;
    end
    chk("starve_cpu_grants", n, HMW);
    chk("starve_stall", s_c_stall, 1);
    idle();
    beat = 0; run = 0; maxrun = 0;
    for (int i = 0; i < 60 && beat < 20; i++) begin
      cyc(1, 0, 16'(i % 16), 0, 1, 1, 16'(beat % 16), $urandom, 0);
      if (s_h_ready) begin beat++; run++; end
      else run = 0;
      if (run > maxrun) maxrun = run;
    end
    chk("burst_beats", beat, 20);
    chk("burst_run", maxrun, BM);
    idle();
    cyc(0, 0, 0, 0, 1, 1, 16'h1, 32'h11, 0);
    cyc(1, 0, 16'h2, 0, 1, 1, 16'h2, 32'h22, 0);
    cyc(1, 0, 16'h2, 0, 1, 1, 16'h3, 32'h33, 0);
    chk("gap_burst_stall", s_c_stall, 1);
    cyc(1, 0, 16'h2, 0, 0, 0, 0, 0, 0);
    chk("gap_stall", s_c_stall, 1);
    cyc(1, 0, 16'h2, 0, 0, 0, 0, 0, 0);
    chk("gap_cpu_served", s_c_stall, 0);
    idle();
    cyc(0, 0, 0, 0, 1, 0, 16'h4, 0, 0);
    run = s_h_ready ? 1 : 0;
    for (int i = 0; i < 30; i++) begin
      cyc(1, 0, 16'h5, 0, 1, 0, 16'(i % 16), 0, 0);
      if (!s_h_ready) break;
      run++;
    end
    chk("post_gap_burst", run, BM);
    idle(); idle();
    cyc(0, 0, 0, 0, 1, 0, 16'h1, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 16'h2, 0, 0);
    c_req = 1; h_valid = 1; h_we = 0; h_last = 0;
    #1 rst_n = 0;
    #1;
    chk("rst_mid_rvalid", h_rvalid, 0);
    chk("rst_mid_stall", c_stall, 0);
    chk("rst_mid_ready", h_ready, 0);
    c_req = 0; h_valid = 0;
    #1 rst_n = 1;
    model_reset();
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(1, 0), $urandom_range(1, 0), 16'($urandom_range(15, 0)), $urandom,
          $urandom_range(9, 0) < 6, $urandom_range(1, 0), 16'($urandom_range(15, 0)), $urandom,
          $urandom_range(3, 0) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
